// File: rtl/muldiv_defs.sv
// Shared opcodes, FSM states and datapath mode for the iterative multiply/divide unit.
package muldiv_defs;

    localparam int MD_WIDTH = 32;

    // These codes are kept disjoint from the ALU ctl space so decode can share the field.
    localparam logic [3:0] MD_MULT  = 4'b1000;
    localparam logic [3:0] MD_MULTU = 4'b1001;
    localparam logic [3:0] MD_DIV   = 4'b1010;
    localparam logic [3:0] MD_DIVU  = 4'b1011;
    localparam logic [3:0] MD_MTHI  = 4'b1110;
    localparam logic [3:0] MD_MTLO  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mode_e;

    function automatic logic isMulDiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on {acc, low}.
module muldiv_step
    import muldiv_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  mode_e            mode_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] low_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] low_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = acc_i + {1'b0, opnd_i};
        shifted = {acc_i[WIDTH-1:0], low_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd_i};
        acc_o   = acc_i;
        low_o   = low_i;

        if (mode_i == MODE_MUL) begin
            // The multiplier LSB decides the add; product bits drop into low as it shifts out.
            if (low_i[0]) begin
                acc_o = {1'b0, sum[WIDTH:1]};
                low_o = {sum[0], low_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[WIDTH:1]};
                low_o = {acc_i[0], low_i[WIDTH-1:1]};
            end
        end else begin
            if (!diff[WIDTH+1]) begin
                acc_o = diff[WIDTH:0];
                low_o = {low_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted;
                low_o = {low_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative MIPS multiply/divide unit: 32 iterations plus a sign-fix cycle, HI/LO owned here.
module muldiv
    import muldiv_defs::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negMain_q, negMain_d;
    logic             negRem_q, negRem_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]     stepAcc;
    logic [WIDTH-1:0]   stepLow;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] prodMag, prodFinal;
    logic [WIDTH-1:0]   quotFinal, remFinal;
    logic               signedOp;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .low_i  (low_q),
        .opnd_i (opnd_q),
        .acc_o  (stepAcc),
        .low_o  (stepLow)
    );

    // The most negative value negates to itself and is then simply read as unsigned.
    assign signedOp  = isSignedOp(ctl);
    assign magA      = (signedOp && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign magB      = (signedOp && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

    assign prodMag   = {acc_q[WIDTH-1:0], low_q};
    assign prodFinal = negMain_q ? ((2*WIDTH)'(0) - prodMag) : prodMag;
    assign quotFinal = negMain_q ? (WIDTH'(0) - low_q) : low_q;
    assign remFinal  = negRem_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_MUL;
            cnt_q      <= '0;
            negMain_q  <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            acc_q      <= '0;
            low_q      <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            negMain_q  <= negMain_d;
            negRem_q   <= negRem_d;
            divZero_q  <= divZero_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            opnd_q     <= opnd_d;
            dividend_q <= dividend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        negMain_d  = negMain_q;
        negRem_d   = negRem_q;
        divZero_d  = divZero_q;
        acc_d      = acc_q;
        low_d      = low_q;
        opnd_d     = opnd_q;
        dividend_d = dividend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (ctl == MD_MTHI)) begin
                    hi_d   = a;
                    done_d = 1'b1;
                end else if (start && (ctl == MD_MTLO)) begin
                    lo_d   = a;
                    done_d = 1'b1;
                end else if (start && isMulDiv(ctl)) begin
                    negMain_d  = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                    negRem_d   = signedOp && a[WIDTH-1];
                    divZero_d  = (b == '0);
                    dividend_d = a;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                    // Divide shifts the dividend out of low; multiply shifts the multiplier.
                    if ((ctl == MD_DIV) || (ctl == MD_DIVU)) begin
                        mode_d = MODE_DIV;
                        low_d  = magA;
                        opnd_d = magB;
                    end else begin
                        mode_d = MODE_MUL;
                        low_d  = magB;
                        opnd_d = magA;
                    end
                end
            end
            S_RUN: begin
                acc_d = stepAcc;
                low_d = stepLow;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (mode_q == MODE_MUL) begin
                    hi_d = prodFinal[2*WIDTH-1:WIDTH];
                    lo_d = prodFinal[WIDTH-1:0];
                end else if (divZero_q) begin
                    hi_d = dividend_q;
                    lo_d = '1;
                end else begin
                    hi_d = remFinal;
                    lo_d = quotFinal;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Randomized and directed bench for muldiv against a plain-arithmetic HI/LO model.
module tb_muldiv;
    import muldiv_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] hiM = '0;
    logic [31:0] loM = '0;

    always #5 clk = ~clk;

    muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ctl   (ctl),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Architectural result computed straight from the instruction semantics.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] pu;
        longint      ps;
        longint      q;
        longint      r;
        case (op)
            MD_MULT: begin
                ps = longint'($signed(av)) * longint'($signed(bv));
                {hiM, loM} = ps;
            end
            MD_MULTU: begin
                pu = {32'b0, av} * {32'b0, bv};
                {hiM, loM} = pu;
            end
            MD_DIV: begin
                if (bv == 0) begin
                    hiM = av;
                    loM = 32'hFFFF_FFFF;
                end else begin
                    q   = longint'($signed(av)) / longint'($signed(bv));
                    r   = longint'($signed(av)) % longint'($signed(bv));
                    loM = q[31:0];
                    hiM = r[31:0];
                end
            end
            MD_DIVU: begin
                if (bv == 0) begin
                    hiM = av;
                    loM = 32'hFFFF_FFFF;
                end else begin
                    loM = av / bv;
                    hiM = av % bv;
                end
            end
            MD_MTHI: hiM = av;
            MD_MTLO: loM = av;
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input string tag);
        logic        isMd;
        int          cycles;
        logic [31:0] prevHi;
        logic [31:0] prevLo;
        isMd   = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        prevHi = hiM;
        prevLo = loM;
        modelOp(op, av, bv);
        @(negedge clk);
        start = 1'b1;
        ctl   = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ctl   = 4'($urandom);
        checkOutput({tag, ".busy"}, 64'(busy), 64'(isMd));
        cycles = 0;
        while (!done && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 16) begin
                checkOutput({tag, ".holdHi"}, 64'(hi), 64'(prevHi));
                checkOutput({tag, ".holdLo"}, 64'(lo), 64'(prevLo));
            end
        end
        checkOutput({tag, ".latency"}, 64'(cycles), isMd ? 64'd33 : 64'd0);
        checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
        checkOutput({tag, ".hi"}, 64'(hi), 64'(hiM));
        checkOutput({tag, ".lo"}, 64'(lo), 64'(loM));
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pickValue();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] opTable [6];
        logic [3:0] op;
        logic [31:0] av;
        logic [31:0] bv;
        int doneCount;

        opTable = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        reset = 1'b1;
        start = 1'b0;
        ctl   = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.hi", 64'(hi), 64'd0);
        checkOutput("reset.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multuMax");
        applyStimulus(MD_MULT, 32'hFFFF_FFF9, 32'd3, "multNeg");
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, "divNeg");
        applyStimulus(MD_DIVU, 32'd100, 32'd7, "divu100");
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divOverflow");
        applyStimulus(MD_DIVU, 32'd5, 32'd0, "divuZero");
        applyStimulus(MD_DIV, 32'hFFFF_FFF0, 32'd0, "divZero");

        // Back-to-back moves: each done is visible in the cycle right after its edge.
        @(negedge clk);
        start = 1'b1;
        ctl   = MD_MTHI;
        a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        checkOutput("mthi.done", 64'(done), 64'd1);
        checkOutput("mthi.busy", 64'(busy), 64'd0);
        checkOutput("mthi.hi", 64'(hi), 64'h1234_5678);
        @(negedge clk);
        ctl = MD_MTLO;
        a   = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        checkOutput("mtlo.done", 64'(done), 64'd1);
        checkOutput("mtlo.busy", 64'(busy), 64'd0);
        checkOutput("mtlo.lo", 64'(lo), 64'h9ABC_DEF0);
        checkOutput("mtlo.hiKept", 64'(hi), 64'h1234_5678);
        hiM = 32'h1234_5678;
        loM = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mtlo.donePulse", 64'(done), 64'd0);

        @(negedge clk);
        start = 1'b1;
        ctl   = 4'b0010;
        a     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("badOp.busy", 64'(busy), 64'd0);
        checkOutput("badOp.done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("badOp.hi", 64'(hi), 64'(hiM));
        checkOutput("badOp.lo", 64'(lo), 64'(loM));

        // A second start mid-flight must not disturb the first operation.
        modelOp(MD_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        start = 1'b1;
        ctl   = MD_MULTU;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        ctl   = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        doneCount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("ignoreStart.doneCount", 64'(doneCount), 64'd1);
        checkOutput("ignoreStart.hi", 64'(hi), 64'(hiM));
        checkOutput("ignoreStart.lo", 64'(lo), 64'(loM));

        // Reset mid-divide aborts it and clears HI/LO.
        @(negedge clk);
        start = 1'b1;
        ctl   = MD_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hiM = '0;
        loM = '0;
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.done", 64'(done), 64'd0);
        checkOutput("midReset.hi", 64'(hi), 64'd0);
        checkOutput("midReset.lo", 64'(lo), 64'd0);
        doneCount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("midReset.noDone", 64'(doneCount), 64'd0);
        applyStimulus(MD_MULTU, 32'd2, 32'd2, "afterReset");

        for (int i = 0; i < 24; i++) begin
            op = opTable[$urandom_range(0, 5)];
            av = pickValue();
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : pickValue();
            applyStimulus(op, av, bv, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
